// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_types_pkg: shared CPU types, including data-cache frame and FSM types |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int DCACHE_SETS_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FILL  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } dcache_state_t;

    // Tag field is sized for the smallest legal index; shorter tags are zero-extended.
    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [29:0] tag;
        word_t       data;
    } dcache_frame_t;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_array: frame storage, two async read ports, one sync write port    |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
module dcache_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = DCACHE_SETS_DEFAULT,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [IDX_W-1:0]   rd_idx,
    output dcache_frame_t      rd_frame,
    input  logic [IDX_W-1:0]   fl_idx,
    output dcache_frame_t      fl_frame,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_idx,
    input  dcache_frame_t      wr_frame
);

    dcache_frame_t frames_q [SETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else if (we) begin
            frames_q[wr_idx] <= wr_frame;
        end
    end

    assign rd_frame = frames_q[rd_idx];
    assign fl_frame = frames_q[fl_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_ctrl: direct-mapped write-back/write-allocate data cache with flush|
// | Optional hit/miss counters under macro DCACHE_STATS_EN.  Rev 1.0          |
// +----------------------------------------------------------------------------+
module dcache_ctrl
    import cpu_types_pkg::*;
#(
    parameter int SETS = DCACHE_SETS_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  word_t       dmemaddr,
    input  word_t       dmemstore,
    output logic        dhit,
    output word_t       dmemload,
    input  logic        halt,
    output logic        flushed,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic        ramready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    dcache_state_t    state_q, state_d;
    logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
    word_t            miss_addr_q, miss_addr_d;

    logic             req;
    logic [IDX_W-1:0] req_idx, miss_idx, lk_idx;
    logic [29:0]      req_tag, miss_tag;
    logic             lk_hit;
    logic             advance;
    logic             hit_ev, miss_ev;

    dcache_frame_t    lk_frame, fl_frame, wr_frame;
    logic             we;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_ok;

    assign req      = dmemREN | dmemWEN;
    assign req_idx  = dmemaddr[IDX_W+1:2];
    assign req_tag  = {{IDX_W{1'b0}}, dmemaddr[31:IDX_W+2]};
    assign miss_idx = miss_addr_q[IDX_W+1:2];
    assign miss_tag = {{IDX_W{1'b0}}, miss_addr_q[31:IDX_W+2]};
    // Once a miss is outstanding the array is addressed by the latched miss,
    // so a requester that drops or changes its address cannot disturb WB/FILL.
    assign lk_idx   = (state_q == IDLE) ? req_idx : miss_idx;
    assign lk_hit   = (state_q == IDLE) && req && lk_frame.valid && (lk_frame.tag == req_tag);
    assign flushed  = (state_q == DONE);
    assign unused_ok = ^{dmemaddr[1:0], miss_addr_q[1:0], lk_frame.tag[29:TAG_W], fl_frame.tag[29:TAG_W]};

    dcache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_array (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (lk_idx),
        .rd_frame (lk_frame),
        .fl_idx   (flush_idx_q),
        .fl_frame (fl_frame),
        .we       (we),
        .wr_idx   (wr_idx),
        .wr_frame (wr_frame)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            flush_idx_q <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        miss_addr_d = miss_addr_q;
        dhit        = 1'b0;
        dmemload    = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        we          = 1'b0;
        wr_idx      = lk_idx;
        wr_frame    = lk_frame;
        advance     = 1'b0;
        hit_ev      = 1'b0;
        miss_ev     = 1'b0;

        case (state_q)
            IDLE: begin
                if (lk_hit) begin
                    dhit     = 1'b1;
                    dmemload = lk_frame.data;
                    hit_ev   = 1'b1;
                    if (dmemWEN) begin
                        we             = 1'b1;
                        wr_frame.dirty = 1'b1;
                        wr_frame.data  = dmemstore;
                    end
                end else if (req) begin
                    miss_ev     = 1'b1;
                    miss_addr_d = dmemaddr;
                    state_d     = (lk_frame.valid && lk_frame.dirty) ? WB : FILL;
                end else if (halt) begin
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = {lk_frame.tag[TAG_W-1:0], miss_idx, 2'b00};
                ramstore = lk_frame.data;
                if (ramready) begin
                    we             = 1'b1;
                    wr_frame.dirty = 1'b0;
                    state_d        = FILL;
                end
            end
            FILL: begin
                ramREN  = 1'b1;
                ramaddr = {miss_addr_q[31:2], 2'b00};
                if (ramready) begin
                    we             = 1'b1;
                    wr_frame.valid = 1'b1;
                    wr_frame.dirty = 1'b0;
                    wr_frame.tag   = miss_tag;
                    wr_frame.data  = ramload;
                    state_d        = IDLE;
                end
            end
            FLUSH: begin
                if (fl_frame.valid && fl_frame.dirty) begin
                    ramWEN   = 1'b1;
                    ramaddr  = {fl_frame.tag[TAG_W-1:0], flush_idx_q, 2'b00};
                    ramstore = fl_frame.data;
                    if (ramready) begin
                        we             = 1'b1;
                        wr_idx         = flush_idx_q;
                        wr_frame       = fl_frame;
                        wr_frame.dirty = 1'b0;
                        advance        = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (flush_idx_q == IDX_W'(SETS - 1)) begin
                        state_d = DONE;
                    end else begin
                        flush_idx_d = flush_idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        after_fill_q, after_fill_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // The hit that retires a filled request was already counted as its miss.
    always_comb begin
        after_fill_d = after_fill_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == FILL && ramready) begin
            after_fill_d = 1'b1;
        end else if (state_q == IDLE) begin
            after_fill_d = 1'b0;
        end
        if (hit_ev && !after_fill_q && hit_count_q != 32'hFFFF_FFFF) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_ev && miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            after_fill_q <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            after_fill_q <= after_fill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_ev;
    assign unused_ev = hit_ev ^ miss_ev;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcache_ctrl: directed self-checking bench for dcache_ctrl (SETS = 16)   |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
module tb_dcache_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt, ramready;
    logic [31:0] dmemaddr, dmemstore, ramload;
    logic        dhit, flushed, ramREN, ramWEN;
    logic [31:0] dmemload, ramaddr, ramstore;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dcache_ctrl #(.SETS(16)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .halt      (halt),
        .flushed   (flushed),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramready  (ramready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; dmemREN = 0; dmemWEN = 0; halt = 0; ramready = 0;
        dmemaddr = 0; dmemstore = 0; ramload = 0;
        next_cycle(); next_cycle();
        nRST = 1'b1;
        #1;
        checks++; if (dhit !== 1'b0)      begin errors++; $display("FAIL reset_dhit: got %b want 0", dhit); end
        checks++; if (dmemload !== 32'h0) begin errors++; $display("FAIL reset_dmemload: got %h want 0", dmemload); end
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL reset_strobes: got REN=%b WEN=%b want 0 0", ramREN, ramWEN); end
        checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramaddr: got %h/%h want 0/0", ramaddr, ramstore); end
        checks++; if (flushed !== 1'b0)   begin errors++; $display("FAIL reset_flushed: got %b want 0", flushed); end
`ifdef DCACHE_STATS_EN
        checks++; if (hit_count !== 0 || miss_count !== 0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
    endtask

    task automatic test_cold_read();
        next_cycle();
        ramready = 1; ramload = 32'hDEADBEEF; dmemREN = 1; dmemaddr = 32'h40;
        #1;
        checks++; if (dhit !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL cold_c0: got dhit=%b REN=%b want 0 0", dhit, ramREN); end
        @(posedge CLK); #2;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || dhit !== 1'b0) begin errors++; $display("FAIL cold_fill: got REN=%b addr=%h dhit=%b want 1 40 0", ramREN, ramaddr, dhit); end
        @(posedge CLK); #2;
        checks++; if (dhit !== 1'b1 || dmemload !== 32'hDEADBEEF || ramREN !== 1'b0) begin errors++; $display("FAIL cold_hit: got dhit=%b load=%h REN=%b want 1 deadbeef 0", dhit, dmemload, ramREN); end
        @(posedge CLK); #2;
        checks++; if (dhit !== 1'b1 || dmemload !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_rehit: got dhit=%b load=%h want 1 deadbeef", dhit, dmemload); end
        next_cycle();
        dmemREN = 0;
    endtask

    task automatic test_write_hit();
        dmemWEN = 1; dmemaddr = 32'h40; dmemstore = 32'h12345678;
        #1;
        checks++; if (dhit !== 1'b1 || ramWEN !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL write_hit: got dhit=%b WEN=%b REN=%b want 1 0 0", dhit, ramWEN, ramREN); end
        next_cycle();
        dmemWEN = 0; dmemREN = 1;
        #1;
        checks++; if (dhit !== 1'b1 || dmemload !== 32'h12345678) begin errors++; $display("FAIL write_readback: got dhit=%b load=%h want 1 12345678", dhit, dmemload); end
        next_cycle();
        dmemREN = 0;
    endtask

    task automatic test_dirty_conflict();
        dmemREN = 1; dmemaddr = 32'h440; ramload = 32'hCAFEF00D; ramready = 1;
        #1;
        checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL conflict_c0: got dhit=%b want 0", dhit); end
        @(posedge CLK); #2;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h40 || ramstore !== 32'h12345678) begin errors++; $display("FAIL conflict_wb: got WEN=%b REN=%b addr=%h store=%h want 1 0 40 12345678", ramWEN, ramREN, ramaddr, ramstore); end
        @(posedge CLK); #2;
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h440) begin errors++; $display("FAIL conflict_fill: got REN=%b WEN=%b addr=%h want 1 0 440", ramREN, ramWEN, ramaddr); end
        @(posedge CLK); #2;
        checks++; if (dhit !== 1'b1 || dmemload !== 32'hCAFEF00D) begin errors++; $display("FAIL conflict_hit: got dhit=%b load=%h want 1 cafef00d", dhit, dmemload); end
        next_cycle();
        dmemREN = 0;
    endtask

    task automatic test_fill_wait();
        ramready = 0; dmemREN = 1; dmemaddr = 32'h80;
        #1;
        checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL wait_c0: got dhit=%b want 0", dhit); end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #2;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || dhit !== 1'b0) begin errors++; $display("FAIL wait_hold%0d: got REN=%b addr=%h dhit=%b want 1 80 0", i, ramREN, ramaddr, dhit); end
        end
        next_cycle();
        ramready = 1; ramload = 32'h0BADF00D;
        #1;
        checks++; if (ramREN !== 1'b1 || dhit !== 1'b0) begin errors++; $display("FAIL wait_ready: got REN=%b dhit=%b want 1 0", ramREN, dhit); end
        @(posedge CLK); #2;
        checks++; if (dhit !== 1'b1 || dmemload !== 32'h0BADF00D) begin errors++; $display("FAIL wait_hit: got dhit=%b load=%h want 1 0badf00d", dhit, dmemload); end
        next_cycle();
        dmemREN = 0;
    endtask

    task automatic test_flush();
        int          n_wb;
        int          rd_seen;
        logic [31:0] wb_addr [2];
        logic [31:0] wb_data [2];
        n_wb = 0; rd_seen = 0;
        wb_addr[0] = 0; wb_addr[1] = 0; wb_data[0] = 0; wb_data[1] = 0;
        // Write misses to index 3 and 9 leave exactly those frames dirty.
        ramready = 1; ramload = 32'h0;
        dmemWEN = 1; dmemaddr = 32'h0C; dmemstore = 32'h11110003;
        @(posedge CLK); @(posedge CLK); #2;
        checks++; if (dhit !== 1'b1) begin errors++; $display("FAIL flush_wr3: got dhit=%b want 1", dhit); end
        next_cycle();
        dmemaddr = 32'h24; dmemstore = 32'h22220009;
        @(posedge CLK); @(posedge CLK); #2;
        checks++; if (dhit !== 1'b1) begin errors++; $display("FAIL flush_wr9: got dhit=%b want 1", dhit); end
        next_cycle();
        dmemWEN = 0; halt = 1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (flushed) break;
            if (ramREN) rd_seen++;
            if (ramWEN) begin
                if (n_wb < 2) begin
                    wb_addr[n_wb] = ramaddr;
                    wb_data[n_wb] = ramstore;
                end
                n_wb++;
            end
            @(posedge CLK); #2;
        end
        checks++; if (flushed !== 1'b1) begin errors++; $display("FAIL flush_done: got flushed=%b want 1 within 40 cycles", flushed); end
        checks++; if (n_wb != 2 || rd_seen != 0) begin errors++; $display("FAIL flush_bursts: got %0d writes %0d reads want 2 0", n_wb, rd_seen); end
        checks++; if (wb_addr[0] !== 32'h0C || wb_data[0] !== 32'h11110003) begin errors++; $display("FAIL flush_wb0: got %h/%h want 0000000c/11110003", wb_addr[0], wb_data[0]); end
        checks++; if (wb_addr[1] !== 32'h24 || wb_data[1] !== 32'h22220009) begin errors++; $display("FAIL flush_wb1: got %h/%h want 00000024/22220009", wb_addr[1], wb_data[1]); end
        next_cycle();
        halt = 0; dmemREN = 1; dmemaddr = 32'h0C;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (dhit !== 1'b0 || flushed !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL flush_sticky%0d: got dhit=%b flushed=%b REN=%b WEN=%b want 0 1 0 0", i, dhit, flushed, ramREN, ramWEN); end
            next_cycle();
        end
        dmemREN = 0;
    endtask

    task automatic test_reset_abort();
        nRST = 0;
        next_cycle();
        nRST = 1; ramready = 0; dmemREN = 1; dmemaddr = 32'h300;
        @(posedge CLK); #2;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL abort_fill: got REN=%b want 1", ramREN); end
        nRST = 0;
        #1;
        checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dhit !== 1'b0) begin errors++; $display("FAIL abort_reset: got REN=%b addr=%h dhit=%b want 0 0 0", ramREN, ramaddr, dhit); end
        dmemREN = 0;
        next_cycle();
        nRST = 1;
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        ramready = 1; ramload = 32'h5A5A5A5A; dmemREN = 1; dmemaddr = 32'h200;
        @(posedge CLK); @(posedge CLK); #2;
        checks++; if (dhit !== 1'b1) begin errors++; $display("FAIL stats_fill: got dhit=%b want 1", dhit); end
        next_cycle();
        dmemREN = 0;
        next_cycle();
        dmemREN = 1;
        next_cycle();
        dmemREN = 0;
        next_cycle();
        dmemREN = 1;
        next_cycle();
        dmemREN = 0;
        #1;
        checks++; if (miss_count !== 32'd1 || hit_count !== 32'd2) begin errors++; $display("FAIL stats_counts: got miss=%0d hit=%0d want 1 2", miss_count, hit_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_conflict();
        test_fill_wait();
        test_flush();
        test_reset_abort();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Responder end of the data-memory request interface driven by the MEM pipeline stage. It accepts dmemREN/dmemWEN/dmemaddr/dmemstore and returns dhit/dmemload.
- Direct-mapped, write-back, write-allocate data cache with one-word blocks. It sits between the MEM stage and the RAM/arbiter port.
- On halt it writes back all dirty frames, then asserts flushed.

Parameters:
- SETS, 16, number of frames; power of 2, at least 2; IDX_W = log2(SETS).

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- dmemREN  in  1  read request, held until dhit
- dmemWEN  in  1  write request, held until dhit
- dmemaddr  in  32  byte address; bits [1:0] ignored
- dmemstore  in  32  write data
- dhit  out  1  request satisfied this cycle
- dmemload  out  32  read data, valid when dhit && dmemREN
- halt  in  1  pipeline halted; start flush
- flushed  out  1  all dirty data written back; sticky
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM word address, bits [1:0] = 0
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid with ramready
- ramready  in  1  RAM completes the current access this cycle

Behaviour:
- Address split: index = dmemaddr[IDX_W+1:2]; tag = dmemaddr[31:IDX_W+2].
- Each frame holds valid, dirty, tag and a 32-bit data word.
- Reset: all frames have valid=0 and dirty=0; state is IDLE; flush index is 0.
- Reset values of outputs: dhit=0, dmemload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, flushed=0.
- Reset mid-operation aborts any RAM access immediately.
- States: IDLE, WB, FILL, FLUSH, DONE.
- IDLE hit (valid && tag match && request active):
  - dhit=1 combinationally in the same cycle.
  - dmemload = frame data.
  - On a write hit, data <= dmemstore and dirty <= 1 at the clock edge.
  - Zero added latency.
- IDLE miss:
  - If the victim frame is valid && dirty, go to WB; otherwise go to FILL. dhit=0.
- WB:
  - ramWEN=1, ramaddr={victim tag, index, 2'b00}, ramstore=victim data.
  - On ramready, clear dirty and go to FILL.
- FILL:
  - ramREN=1, ramaddr={dmemaddr[31:2], 2'b00}.
  - On ramready, the frame gets valid=1, dirty=0, tag and data=ramload; return to IDLE.
  - The request then hits in IDLE, so a write miss completes through the write-hit path.
- Clean-miss latency with zero-wait RAM:
  - request cycle 0 (miss), FILL cycle 1, dhit cycle 2.
  - A dirty miss adds one WB cycle.
- dmemREN && dmemWEN together is illegal; it is treated as a write.
- A request dropped by the requester while in WB/FILL does not abort the RAM access. The fill completes and the block returns to IDLE.
- halt:
  - Sampled only in IDLE with no miss outstanding; then go to FLUSH with flush index 0.
  - In WB/FILL, halt is deferred until the return to IDLE.
- FLUSH:
  - For frame[idx] valid && dirty: ramWEN=1, ramaddr={tag, idx, 2'b00}, ramstore=data. On ramready, clear dirty and advance idx.
  - Clean or invalid frames advance idx in one cycle with no RAM strobe.
  - After idx = SETS-1 completes, go to DONE.
- DONE:
  - flushed=1, held until reset.
  - dhit=0 and all requests are ignored in FLUSH and DONE.
- ramREN and ramWEN are never high in the same cycle, and both are low in IDLE and DONE.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, adds outputs hit_count [31:0] and miss_count [31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - A request counts exactly once: as a miss if its first IDLE lookup missed, otherwise as a hit.
  - The hit that completes after a fill is not counted.
- When undefined, neither the ports nor the counter logic exist; all other behaviour is identical.

Decomposition:
- cpu_types_pkg gains:
  - dcache_frame_t, a packed struct {valid, dirty, tag, data}
  - dcache_state_t, an enum {IDLE, WB, FILL, FLUSH, DONE}
  - DCACHE_SETS_DEFAULT
  - word_t is reused from the package.
- One natural sub-module: dcache_array, holding the frame storage with an async read port (lookup index and flush index) and one synchronous write port.
- The FSM, hit logic and counters stay in dcache_ctrl.

Test Plan:
- Cold read 0x00000040, ramload=0xDEADBEEF, ramready tied 1 -> ramREN in cycle 1 with ramaddr 0x40; dhit and dmemload=0xDEADBEEF in cycle 2; repeat read hits in the same cycle.
- Write 0x00000040 with 0x12345678 after the fill -> same-cycle dhit, no RAM strobe; a later read returns 0x12345678.
- Conflict read 0x00000440 (same index, SETS=16) with the line dirty -> WB: ramWEN, ramaddr 0x40, ramstore 0x12345678; then FILL with ramaddr 0x440; dhit afterwards.
- ramready held low for 5 cycles during FILL -> ramREN and ramaddr held stable, dhit stays 0, then completes the cycle after ramready.
- Dirty frames at index 3 and 9, halt asserted -> exactly two ramWEN bursts with the correct addresses, flushed=1 afterwards and sticky; subsequent dmemREN gives no dhit.
- Under DCACHE_STATS_EN: miss, hit, hit on the same address -> miss_count=1, hit_count=2.
